stack_cmd_engine: RTL

Command sequencer that sits directly upstream of the 8-entry, 16-bit hardware stack and is its only driver. It accepts stack-machine commands (PUSH, POP, ADD, SUB, AND, OR, XOR, DUP) over a valid/ready handshake. It breaks each command into single-cycle push/pop strobes on the stack port, computes ALU results and returns one response per command. It checks occupancy before issuing anything, so an illegal command never touches the stack.

---
 rtl/stack_cmd_engine_if.sv | 24 ++
 rtl/stack_cmd_engine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stack_cmd_engine_if.sv
// Command/response channel between a command source and stack_cmd_engine.
interface stack_cmd_engine_if #(
    parameter int W = 16
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_imm;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    // Command source side
    modport master (
        output cmd_valid, cmd_op, cmd_imm,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    // Engine side
    modport slave (
        input  cmd_valid, cmd_op, cmd_imm,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_cmd_engine.sv
// Stack-machine command sequencer: turns PUSH/POP/ALU/DUP commands into
// single-cycle push/pop strobes on an external 8-entry stack and returns one
// response per command. Occupancy is checked at accept, so an illegal
// command never strobes the stack.
module stack_cmd_engine #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    stack_cmd_engine_if.slave cmd,
    output logic              stk_en,
    output logic              stk_mode,
    output logic [W-1:0]      stk_data_i,
    input  logic [W-1:0]      stk_data_o,
    input  logic [3:0]        stk_amount
);
    typedef enum logic [2:0] {IDLE, POP_A, POP_B, PUSH_A, PUSH_R, RESP} state_e;
    typedef enum logic [2:0] {
        OP_PUSH = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
        OP_AND  = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_DUP = 3'd7
    } op_e;

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_e       state;
    op_e          op_q;
    op_e          op_in;
    logic [W-1:0] a_q;
    logic [W-1:0] res_q;
    logic         ready_q;
    logic         rsp_valid_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_err_q;

    assign op_in         = op_e'(cmd.cmd_op);
    assign cmd.cmd_ready = ready_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;
    assign cmd.rsp_err   = rsp_err_q;

    // Occupancy rule for each command, evaluated once at accept.
    function automatic logic cmd_legal(input op_e op, input logic [3:0] amt);
        logic ok;
        case (op)
            OP_PUSH: ok = (amt < DEPTH_L);
            OP_POP:  ok = (amt != 4'd0);
            OP_DUP:  ok = (amt != 4'd0) && (amt < DEPTH_L);
            default: ok = (amt >= 4'd2);
        endcase
        return ok;
    endfunction

    // a = old top, b = old second; all arithmetic wraps mod 2^W.
    function automatic logic [W-1:0] alu_result(input op_e op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            OP_ADD:  r = b + a;
            OP_SUB:  r = b - a;
            OP_AND:  r = b & a;
            OP_OR:   r = b | a;
            OP_XOR:  r = b ^ a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Sequencer FSM; every output is registered and set for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_PUSH;
            a_q         <= '0;
            res_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            stk_en      <= 1'b0;
            stk_mode    <= 1'b0;
            stk_data_i  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid && ready_q) begin
                        op_q    <= op_in;
                        ready_q <= 1'b0;
                        if (!cmd_legal(op_in, stk_amount)) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                        end else if (op_in == OP_PUSH) begin
                            state      <= PUSH_R;
                            res_q      <= cmd.cmd_imm;
                            stk_en     <= 1'b1;
                            stk_mode   <= 1'b1;
                            stk_data_i <= cmd.cmd_imm;
                        end else begin
                            state      <= POP_A;
                            stk_en     <= 1'b1;
                            stk_mode   <= 1'b0;
                            stk_data_i <= '0;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                POP_A: begin
                    a_q <= stk_data_o;
                    if (op_q == OP_POP) begin
                        state       <= RESP;
                        res_q       <= stk_data_o;
                        stk_en      <= 1'b0;
                        stk_mode    <= 1'b0;
                        stk_data_i  <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= stk_data_o;
                        rsp_err_q   <= 1'b0;
                    end else if (op_q == OP_DUP) begin
                        state      <= PUSH_A;
                        res_q      <= stk_data_o;
                        stk_en     <= 1'b1;
                        stk_mode   <= 1'b1;
                        stk_data_i <= stk_data_o;
                    end else begin
                        state    <= POP_B;
                        stk_en   <= 1'b1;
                        stk_mode <= 1'b0;
                    end
                end
                // B is taken straight off the stack port at this edge; only the result is kept.
                POP_B: begin
                    state      <= PUSH_R;
                    res_q      <= alu_result(op_q, a_q, stk_data_o);
                    stk_en     <= 1'b1;
                    stk_mode   <= 1'b1;
                    stk_data_i <= alu_result(op_q, a_q, stk_data_o);
                end
                PUSH_A: begin
                    state      <= PUSH_R;
                    stk_en     <= 1'b1;
                    stk_mode   <= 1'b1;
                    stk_data_i <= res_q;
                end
                PUSH_R: begin
                    state       <= RESP;
                    stk_en      <= 1'b0;
                    stk_mode    <= 1'b0;
                    stk_data_i  <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= res_q;
                    rsp_err_q   <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    ready_q    <= 1'b1;
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    stk_en     <= 1'b0;
                    stk_mode   <= 1'b0;
                    stk_data_i <= '0;
                end
            endcase
        end
    end
endmodule
